// File: rtl/instr_enc_pkg.sv
// rtl/instr_enc_pkg.sv - instruction type codes, opcodes and loader state encoding
// Shared by the encoder/loader and the decoder side.
//   instr_type_e : in_type codes 0..8 (9..15 are unassigned and encode as NOP)
//   OP_*         : 7-bit major opcodes, one per instruction type
//   NOP_WORD     : addi x0,x0,0
//   load_state_e : loader FSM states
package instr_enc_pkg;

  typedef enum logic [3:0] {
    TYPE_R     = 4'd0,
    TYPE_I_ALU = 4'd1,
    TYPE_LOAD  = 4'd2,
    TYPE_S     = 4'd3,
    TYPE_B     = 4'd4,
    TYPE_LUI   = 4'd5,
    TYPE_AUIPC = 4'd6,
    TYPE_JAL   = 4'd7,
    TYPE_JALR  = 4'd8
  } instr_type_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I_ALU = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } load_state_e;

endpackage

// File: rtl/instr_field_pack.sv
// rtl/instr_field_pack.sv - combinational packing of instruction fields into a 32-bit word
// Ports:
//   in_type          : instruction type code (instr_type_e; 9..15 give NOP_WORD)
//   rd, rs1, rs2     : register indices
//   funct3, funct7   : function fields
//   imm              : byte offset (I/S/B/J) or upper value (U)
//   word             : packed instruction
module instr_field_pack
  import instr_enc_pkg::*;
(
  input  logic [3:0]  in_type,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = NOP_WORD;
    case (in_type)
      TYPE_R:     word = {funct7, rs2, rs1, funct3, rd, OP_R};
      TYPE_I_ALU: word = {imm[11:0], rs1, funct3, rd, OP_I_ALU};
      TYPE_LOAD:  word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
      TYPE_JALR:  word = {imm[11:0], rs1, funct3, rd, OP_JALR};
      TYPE_S:     word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
      // Branch/jump offsets are even, so bit 0 is never stored.
      TYPE_B:     word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
      TYPE_LUI:   word = {imm[31:12], rd, OP_LUI};
      TYPE_AUIPC: word = {imm[31:12], rd, OP_AUIPC};
      TYPE_JAL:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      default:    word = NOP_WORD;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes instructions and writes them sequentially into imem
// Optional feature macro: INSTR_ENC_ERR_EN (sticky per-session encoding error flag).
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   start, start_addr          : begin a load session at byte address start_addr
//   in_valid/in_ready/in_last  : instruction input handshake, in_last ends the session
//   in_type, rd, rs1, rs2,
//   funct3, funct7, imm        : instruction fields
//   imem_we/addr/wdata/ready   : memory write port, held until imem_ready
//   busy, done, count, err     : session status; done pulses one cycle, count = words written
module instr_encoder_loader
  import instr_enc_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [31:0]                start_addr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [3:0]                 in_type,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [2:0]                 funct3,
  input  logic [6:0]                 funct7,
  input  logic [31:0]                imm,
  output logic                       imem_we,
  output logic [31:0]                imem_addr,
  output logic [31:0]                imem_wdata,
  input  logic                       imem_ready,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH + 1);

  load_state_e   state;
  logic          last_q;
  logic [31:0]   packed_word;
  logic [CW-1:0] count_next;

  instr_field_pack u_pack (
    .in_type (in_type),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .funct3  (funct3),
    .funct7  (funct7),
    .imm     (imm),
    .word    (packed_word)
  );

  assign count_next = count + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_q     <= 1'b0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= 32'd0;
      imem_wdata <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            imem_addr <= start_addr;
            count     <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            imem_wdata <= packed_word;
            last_q     <= in_last;
            in_ready   <= 1'b0;
            imem_we    <= 1'b1;
            state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (imem_ready) begin
            imem_addr <= imem_addr + 32'd4;
            count     <= count_next;
            imem_we   <= 1'b0;
            if (last_q || (count_next == CW'(DEPTH))) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              in_ready <= 1'b1;
              state    <= S_ACCEPT;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef INSTR_ENC_ERR_EN
  logic word_bad;
  logic err_q;

  // Immediate must sign-extend from its encodable width; B/J offsets must be even.
  always_comb begin
    word_bad = 1'b1;
    case (in_type)
      TYPE_R, TYPE_LUI, TYPE_AUIPC:
        word_bad = 1'b0;
      TYPE_I_ALU, TYPE_LOAD, TYPE_JALR, TYPE_S:
        word_bad = (imm[31:11] != {21{imm[11]}});
      TYPE_B:
        word_bad = imm[0] | (imm[31:12] != {20{imm[12]}});
      TYPE_JAL:
        word_bad = imm[0] | (imm[31:20] != {12{imm[20]}});
      default:
        word_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      err_q <= 1'b0;
    end else if ((state == S_ACCEPT) && in_valid && word_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - scoreboard bench for instr_encoder_loader
module tb_instr_encoder_loader;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   start_addr = 32'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [3:0]    in_type = 4'd0;
  logic [4:0]    rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic [2:0]    funct3 = 3'd0;
  logic [6:0]    funct7 = 7'd0;
  logic [31:0]   imm = 32'd0;
  logic          imem_we;
  logic [31:0]   imem_addr, imem_wdata;
  logic          imem_ready = 1'b0;
  logic          busy, done, err;
  logic [CW-1:0] count;

  instr_encoder_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_type(in_type), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ready(imem_ready), .busy(busy), .done(done), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_cnt[$];
  bit  hold_low = 1'b0;

`ifdef INSTR_ENC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout/absent required=event", name);
  endtask

  // Reference encoding: each field shifted to its bit position and OR-ed together.
  function automatic logic [31:0] ref_enc(input int t, input logic [31:0] f_rd, input logic [31:0] f_rs1,
                                          input logic [31:0] f_rs2, input logic [31:0] f3,
                                          input logic [31:0] f7, input logic [31:0] im);
    logic [31:0] base_i;
    base_i = ((im & 32'hfff) << 20) | (f_rs1 << 15) | (f3 << 12) | (f_rd << 7);
    case (t)
      0: return (f7 << 25) | (f_rs2 << 20) | (f_rs1 << 15) | (f3 << 12) | (f_rd << 7) | 32'h33;
      1: return base_i | 32'h13;
      2: return base_i | 32'h03;
      8: return base_i | 32'h67;
      3: return (((im >> 5) & 32'h7f) << 25) | (f_rs2 << 20) | (f_rs1 << 15) | (f3 << 12)
                | ((im & 32'h1f) << 7) | 32'h23;
      4: return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3f) << 25) | (f_rs2 << 20)
                | (f_rs1 << 15) | (f3 << 12) | (((im >> 1) & 32'hf) << 8)
                | (((im >> 11) & 32'h1) << 7) | 32'h63;
      5: return (im & 32'hffff_f000) | (f_rd << 7) | 32'h37;
      6: return (im & 32'hffff_f000) | (f_rd << 7) | 32'h17;
      7: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3ff) << 21)
                | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hff) << 12)
                | (f_rd << 7) | 32'h6f;
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic bit ref_bad(input int t, input logic [31:0] im);
    int s;
    s = signed'(im);
    case (t)
      0, 5, 6:    return 1'b0;
      1, 2, 3, 8: return (s < -2048) || (s > 2047);
      4:          return (im[0] == 1'b1) || (s < -4096) || (s > 4095);
      7:          return (im[0] == 1'b1) || (s < -(1 << 20)) || (s > (1 << 20) - 1);
      default:    return 1'b1;
    endcase
  endfunction

  // Memory ready: random back-pressure unless a directed test holds it low.
  always begin
    @(posedge clk);
    #1;
    imem_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops scoreboard on every completed write and every done pulse.
  logic          prev_pend = 1'b0;
  logic [31:0]   prev_addr, prev_data;
  logic [CW-1:0] prev_cnt;

  always @(negedge clk) begin
    if (reset) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        chk("stall_we", imem_we, 1);
        chk("stall_addr", imem_addr, prev_addr);
        chk("stall_wdata", imem_wdata, prev_data);
        chk("stall_count", count, prev_cnt);
      end
      prev_pend = 1'b0;
      if (imem_we) begin
        chk("in_ready_in_write", in_ready, 0);
        if (imem_ready) begin
          if (exp_wr.size() == 0) begin
            fail_now("unexpected_write");
          end else begin
            wr_t w;
            w = exp_wr.pop_front();
            chk("write_addr", imem_addr, w.addr);
            chk("write_data", imem_wdata, w.data);
          end
        end else begin
          prev_pend = 1'b1;
          prev_addr = imem_addr;
          prev_data = imem_wdata;
          prev_cnt  = count;
        end
      end
      if (done) begin
        if (exp_cnt.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          int c;
          c = exp_cnt.pop_front();
          chk("done_count", count, c);
          chk("done_busy", busy, 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail_now("wait_idle");
    tick();
  endtask

  task automatic begin_session(input logic [31:0] a);
    start = 1'b1;
    start_addr = a;
    tick();
    start = 1'b0;
    start_addr = $urandom;
  endtask

  task automatic send_word(input int t, input int f_rd, input int f_rs1, input int f_rs2,
                           input int f3, input int f7, input logic [31:0] im, input bit last);
    int n;
    in_type = 4'(t);
    rd = 5'(f_rd);
    rs1 = 5'(f_rs1);
    rs2 = 5'(f_rs2);
    funct3 = 3'(f3);
    funct7 = 7'(f7);
    imm = im;
    in_last = last;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 400) begin
        fail_now("accept_timeout");
        break;
      end
    end
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    imm = $urandom;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst_we", imem_we, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_count", count, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    tick();
    reset = 1'b0;
    tick();

    // Single I-type word
    begin_session(32'h100);
    push_wr(32'h100, 32'h0050_0093);
    exp_cnt.push_back(1);
    send_word(1, 1, 0, 0, 0, 0, 32'd5, 1'b1);
    wait_idle();
    chk("single_count", count, 1);
    chk("single_addr_held", imem_addr, 32'h104);
    chk("single_err", err, 0);

    // Back-to-back R, S, LUI
    begin_session(32'h200);
    push_wr(32'h200, 32'h0020_81B3);
    push_wr(32'h204, 32'h0020_A423);
    push_wr(32'h208, 32'h1234_52B7);
    exp_cnt.push_back(3);
    send_word(0, 3, 1, 2, 0, 0, $urandom, 1'b0);
    send_word(3, $urandom_range(0, 31), 1, 2, 2, $urandom_range(0, 127), 32'd8, 1'b0);
    send_word(5, 5, $urandom_range(0, 31), $urandom_range(0, 31), 0, 0, 32'h1234_5000, 1'b1);
    wait_idle();
    chk("rsl_count", count, 3);

    // Branch and jump
    begin_session(32'h300);
    push_wr(32'h300, 32'hFE20_8EE3);
    push_wr(32'h304, 32'h0080_00EF);
    exp_cnt.push_back(2);
    send_word(4, 0, 1, 2, 0, 0, 32'hFFFF_FFFC, 1'b0);
    send_word(7, 1, 0, 0, 0, 0, 32'd8, 1'b1);
    wait_idle();
    chk("bj_count", count, 2);

    // Memory stall for 5 cycles
    hold_low = 1'b1;
    tick();
    begin_session(32'h500);
    push_wr(32'h500, ref_enc(2, 7, 3, 0, 2, 0, 32'h10));
    exp_cnt.push_back(1);
    send_word(2, 7, 3, 0, 2, 0, 32'h10, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_count_zero", count, 0);
    end
    tick();
    hold_low = 1'b0;
    wait_idle();
    chk("stall_final_count", count, 1);

    // DEPTH limit: more words offered than fit
    begin_session(32'h400);
    for (int i = 0; i < DEPTH; i++) push_wr(32'h400 + 32'(4 * i), ref_enc(1, i, i, 0, 0, 0, 32'(i)));
    exp_cnt.push_back(DEPTH);
    for (int i = 0; i < DEPTH; i++) send_word(1, i, i, 0, 0, 0, 32'(i), 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("depth_no_more_accept", in_ready, 0);
    end
    in_valid = 1'b0;
    wait_idle();
    chk("depth_count", count, DEPTH);
    chk("depth_addr_held", imem_addr, 32'h410);

    // Address wrap
    begin_session(32'hFFFF_FFFC);
    push_wr(32'hFFFF_FFFC, ref_enc(1, 2, 2, 0, 0, 0, 32'd1));
    push_wr(32'h0000_0000, ref_enc(1, 3, 3, 0, 0, 0, 32'd2));
    exp_cnt.push_back(2);
    send_word(1, 2, 2, 0, 0, 0, 32'd1, 1'b0);
    send_word(1, 3, 3, 0, 0, 0, 32'd2, 1'b1);
    wait_idle();
    chk("wrap_addr", imem_addr, 32'h4);

    // Undefined type and odd branch offset
    begin_session(32'h700);
    push_wr(32'h700, 32'h0000_0013);
    exp_cnt.push_back(1);
    send_word(12, 9, 9, 9, 7, 127, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    chk("nop_err", err, 32'(ERR_EN));
    begin_session(32'h800);
    push_wr(32'h800, ref_enc(4, 0, 1, 2, 0, 0, 32'd3));
    exp_cnt.push_back(1);
    send_word(4, 0, 1, 2, 0, 0, 32'd3, 1'b1);
    wait_idle();
    chk("odd_branch_err", err, 32'(ERR_EN));

    // Reset during a pending write
    hold_low = 1'b1;
    tick();
    begin_session(32'h900);
    send_word(0, 1, 1, 1, 0, 0, 32'd0, 1'b0);
    @(negedge clk);
    chk("pre_reset_we", imem_we, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_we", imem_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", count, 0);
    chk("midrst_addr", imem_addr, 0);
    chk("midrst_wdata", imem_wdata, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_done", done, 0);
    hold_low = 1'b0;
    tick();

    // Randomised sessions against the reference model
    for (int s = 0; s < 25; s++) begin
      int n;
      bit e;
      logic [31:0] a;
      n = $urandom_range(1, DEPTH);
      a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3)))
                                      : ($urandom & 32'hFFFF_FFFC);
      e = 1'b0;
      begin_session(a);
      for (int i = 0; i < n; i++) begin
        int t, f_rd, f_rs1, f_rs2, f3, f7;
        logic [31:0] im;
        bit last;
        t = $urandom_range(0, 15);
        if (t > 8 && $urandom_range(0, 2) != 0) t = $urandom_range(0, 8);
        f_rd = $urandom_range(0, 31);
        f_rs1 = $urandom_range(0, 31);
        f_rs2 = $urandom_range(0, 31);
        f3 = $urandom_range(0, 7);
        f7 = $urandom_range(0, 127);
        case ($urandom_range(0, 2))
          0: im = 32'($urandom_range(0, 4095)) - 32'd2048;
          1: im = (32'($urandom_range(0, 2047)) - 32'd1024) << 1;
          default: im = $urandom;
        endcase
        last = (i == n - 1) && ((n < DEPTH) || ($urandom_range(0, 1) == 1));
        push_wr(a + 32'(4 * i), ref_enc(t, f_rd, f_rs1, f_rs2, f3, f7, im));
        e = e | ref_bad(t, im);
        send_word(t, f_rd, f_rs1, f_rs2, f3, f7, im, last);
      end
      exp_cnt.push_back(n);
      wait_idle();
      chk("rand_count", count, n);
      chk("rand_addr", imem_addr, a + 32'(4 * n));
      chk("rand_err", err, 32'(ERR_EN && e));
    end

    repeat (5) tick();
    chk("leftover_writes", exp_wr.size(), 0);
    chk("leftover_done", exp_cnt.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
